// File: rtl/timer_counter.sv
// ============================================================================
// timer_counter
// ----------------------------------------------------------------------------
// Counting core of the APB timer. Holds the control register (TCR), the
// 64-bit up-counter (TDR1:TDR0) and the 64-bit compare value (TCMP1:TCMP0).
// The interrupt stage downstream consumes cnt and tcmp directly.
//
// A prescaler divides clk by 2^div_val when div_en is set. Each tick adds one
// to cnt with full 64-bit carry. All-ones wraps silently to zero.
//
// Optional feature (compile-time macro TIMER_HALT_EN):
//   Adds the debug-halt register THCSR at 0x1C, plus ports dbg_mode and thcsr.
//   While halt_ack (dbg_mode & halt_req) is high, ticks are suppressed and the
//   prescaler freezes. Register writes still apply during the halt.
//   Without the macro, 0x1C is an unmapped address.
//
// Parameters:
//   DIV_MAX   largest legal div_val (ratio = 2^div_val)
//   TCMP_RST  reset value of the compare register
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous, active-low reset
//   wr_en     in   register write strobe, one cycle per APB access phase
//   addr      in   byte address: 0x00 TCR, 0x04 TDR0, 0x08 TDR1,
//                  0x0C TCMP0, 0x10 TCMP1 (0x1C THCSR with TIMER_HALT_EN)
//   wdata     in   write data
//   wr_err    out  combinational; high with wr_en when a TCR write is rejected
//   tcr       out  {20'h0, div_val[11:8], 6'h0, div_en[1], timer_en[0]}
//   cnt       out  counter value; TDR1 = [63:32], TDR0 = [31:0]
//   tcmp      out  compare value
//   dbg_mode  in   debug mode indication          (TIMER_HALT_EN only)
//   thcsr     out  {30'h0, halt_ack, halt_req}    (TIMER_HALT_EN only)
// ============================================================================
module timer_counter #(
    parameter int          DIV_MAX  = 8,
    parameter logic [63:0] TCMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        wr_err,
    output logic [31:0] tcr,
    output logic [63:0] cnt,
    output logic [63:0] tcmp
`ifdef TIMER_HALT_EN
    ,
    input  logic        dbg_mode,
    output logic [31:0] thcsr
`endif
);

    localparam logic [31:0] ADDR_TCR   = 32'h00;
    localparam logic [31:0] ADDR_TDR0  = 32'h04;
    localparam logic [31:0] ADDR_TDR1  = 32'h08;
    localparam logic [31:0] ADDR_TCMP0 = 32'h0C;
    localparam logic [31:0] ADDR_TCMP1 = 32'h10;

    // The prescaler must reach 2^DIV_MAX-1, which needs DIV_MAX bits.
    localparam int         PS_W      = (DIV_MAX > 0) ? DIV_MAX : 1;
    localparam logic [3:0] DIV_MAX_V = 4'(DIV_MAX);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic            timer_en;
    logic            div_en;
    logic [3:0]      div_val;
    logic [PS_W-1:0] ps_cnt;

    // ------------------------------------------------------------------------
    // Write decode
    // ------------------------------------------------------------------------
    logic sel_tcr, sel_tdr0, sel_tdr1, sel_tcmp0, sel_tcmp1;
    logic tcr_bad, tcr_ok;

    assign sel_tcr   = wr_en && (addr == ADDR_TCR);
    assign sel_tdr0  = wr_en && (addr == ADDR_TDR0);
    assign sel_tdr1  = wr_en && (addr == ADDR_TDR1);
    assign sel_tcmp0 = wr_en && (addr == ADDR_TCMP0);
    assign sel_tcmp1 = wr_en && (addr == ADDR_TCMP1);

    // A TCR write is rejected if the divider is out of range, or if it alters
    // the divider setup while the timer runs. Toggling only timer_en is always
    // allowed when the divider value itself is legal.
    assign tcr_bad = (wdata[11:8] > DIV_MAX_V) ||
                     (timer_en && ((wdata[1] != div_en) || (wdata[11:8] != div_val)));
    assign tcr_ok  = sel_tcr && !tcr_bad;
    assign wr_err  = sel_tcr && tcr_bad;

    assign tcr = {20'h0, div_val, 6'h0, div_en, timer_en};

    // ------------------------------------------------------------------------
    // Debug halt
    // ------------------------------------------------------------------------
    logic halt_ack;

`ifdef TIMER_HALT_EN
    localparam logic [31:0] ADDR_THCSR = 32'h1C;

    logic halt_req;

    assign halt_ack = dbg_mode & halt_req;
    assign thcsr    = {30'h0, halt_ack, halt_req};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_req <= 1'b0;
        end else if (wr_en && (addr == ADDR_THCSR)) begin
            halt_req <= wdata[0];
        end
    end
`else
    assign halt_ack = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Tick generation
    // ------------------------------------------------------------------------
    logic            running;
    logic            div_active;
    logic [PS_W-1:0] ps_max;
    logic            tick;

    assign running    = timer_en && !halt_ack;
    assign div_active = div_en && (div_val != 4'd0);
    assign ps_max     = PS_W'((32'd1 << div_val) - 32'd1);
    assign tick       = running && (!div_active || (ps_cnt == ps_max));

    // ------------------------------------------------------------------------
    // Control register
    // ------------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_en <= 1'b0;
            div_en   <= 1'b0;
            div_val  <= 4'd1;
        end else if (tcr_ok) begin
            timer_en <= wdata[0];
            div_en   <= wdata[1];
            div_val  <= wdata[11:8];
        end
    end

    // ------------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------------
    // Any TCR write clears the prescaler. The only way timer_en can fall is a
    // TCR write, so the clear on disable is covered by the same condition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_cnt <= '0;
        end else if (sel_tcr) begin
            ps_cnt <= '0;
        end else if (running && div_active) begin
            ps_cnt <= (ps_cnt == ps_max) ? '0 : ps_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Counter
    // ------------------------------------------------------------------------
    // A software write to either half wins over a tick: the written half takes
    // wdata, the other half holds, and that cycle's increment is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 64'h0;
        end else if (sel_tdr0) begin
            cnt[31:0] <= wdata;
        end else if (sel_tdr1) begin
            cnt[63:32] <= wdata;
        end else if (tick) begin
            cnt <= cnt + 64'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Compare register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcmp <= TCMP_RST;
        end else begin
            if (sel_tcmp0) tcmp[31:0]  <= wdata;
            if (sel_tcmp1) tcmp[63:32] <= wdata;
        end
    end

endmodule

// File: tb/tb_timer_counter.sv
// ============================================================================
// tb_timer_counter
// ----------------------------------------------------------------------------
// Self-checking bench for timer_counter. A behavioural model tracks the
// register contents and counts elapsed enabled cycles since the last prescaler
// clear; ticks fall where that count is one short of a multiple of the
// division ratio. A compare process checks every output on each falling
// edge, and directed steps add literal expectations that pin the model.
// Define TIMER_HALT_EN to exercise the debug-halt feature as well.
// ============================================================================
module tb_timer_counter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr_err;
    logic [31:0] tcr;
    logic [63:0] cnt;
    logic [63:0] tcmp;
`ifdef TIMER_HALT_EN
    logic        dbg_mode;
    logic [31:0] thcsr;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    timer_counter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .addr     (addr),
        .wdata    (wdata),
        .wr_err   (wr_err),
        .tcr      (tcr),
        .cnt      (cnt),
        .tcmp     (tcmp)
`ifdef TIMER_HALT_EN
        ,
        .dbg_mode (dbg_mode),
        .thcsr    (thcsr)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------------
    logic        m_ten, m_den;
    logic [3:0]  m_dval;
    logic [63:0] m_cnt, m_tcmp;
    longint unsigned m_phase;  // enabled cycles since last prescaler clear
    logic        m_hreq;

    function automatic logic m_halt();
`ifdef TIMER_HALT_EN
        return dbg_mode && m_hreq;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic m_tick();
        longint unsigned ratio;
        ratio = m_den ? (64'd1 << m_dval) : 64'd1;
        return m_ten && !m_halt() && ((m_phase % ratio) == ratio - 1);
    endfunction

    function automatic logic m_err();
        if (!(wr_en && addr == 32'h0)) return 1'b0;
        if (wdata[11:8] > 4'd8) return 1'b1;
        return m_ten && ((wdata[1] != m_den) || (wdata[11:8] != m_dval));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ten = 1'b0; m_den = 1'b0; m_dval = 4'd1;
            m_cnt = 64'h0; m_tcmp = 64'hFFFF_FFFF_FFFF_FFFF;
            m_phase = 0; m_hreq = 1'b0;
        end else begin
            logic t, e, tcr_wr;
            t = m_tick();
            e = m_err();
            tcr_wr = wr_en && addr == 32'h0;
            // counter
            if (wr_en && addr == 32'h04)      m_cnt = {m_cnt[63:32], wdata};
            else if (wr_en && addr == 32'h08) m_cnt = {wdata, m_cnt[31:0]};
            else if (t)                       m_cnt = m_cnt + 1;
            // phase
            if (tcr_wr)                       m_phase = 0;
            else if (m_ten && !m_halt())      m_phase = m_phase + 1;
            // registers
            if (tcr_wr && !e) begin
                m_ten = wdata[0]; m_den = wdata[1]; m_dval = wdata[11:8];
            end
            if (wr_en && addr == 32'h0C) m_tcmp[31:0]  = wdata;
            if (wr_en && addr == 32'h10) m_tcmp[63:32] = wdata;
`ifdef TIMER_HALT_EN
            if (wr_en && addr == 32'h1C) m_hreq = wdata[0];
`endif
        end
    end

    // Compare process: every falling edge outside reset.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("cnt",    cnt,  m_cnt);
            check("tcmp",   tcmp, m_tcmp);
            check("tcr",    {32'h0, tcr}, {32'h0, 20'h0, m_dval, 6'h0, m_den, m_ten});
            check("wr_err", {63'h0, wr_err}, {63'h0, m_err()});
`ifdef TIMER_HALT_EN
            check("thcsr",  {32'h0, thcsr}, {32'h0, 30'h0, dbg_mode && m_hreq, m_hreq});
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    logic last_err;

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        wr_en = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        last_err = wr_err;
        @(posedge clk);
        #1;
        wr_en = 1'b0; addr = 32'h0; wdata = 32'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        rst_n = 1'b0; wr_en = 1'b0; addr = 32'h0; wdata = 32'h0;
`ifdef TIMER_HALT_EN
        dbg_mode = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_cnt",  cnt, 64'h0);
        check("rst_tcr",  {32'h0, tcr}, 64'h100);
        check("rst_tcmp", tcmp, 64'hFFFF_FFFF_FFFF_FFFF);
        check("rst_err",  {63'h0, wr_err}, 64'h0);
        rst_n = 1'b1;
        idle(1);

        // compare register halves
        do_write(32'h0C, 32'h10);
        do_write(32'h10, 32'h0);
        check("tcmp_10", tcmp, 64'h10);

        // free-running, one tick per clk
        do_write(32'h0, 32'h1);
        check("run_start", cnt, 64'd0);
        idle(5);
        check("run_5", cnt, 64'd5);

        // divider change while running is rejected (increment still happens)
        do_write(32'h0, 32'h303);
        check("run_rej_err", {63'h0, last_err}, 64'h1);
        check("run_rej_tcr", {32'h0, tcr}, 64'h1);

        // stop: only timer_en changes, accepted; cnt holds
        do_write(32'h0, 32'h0);
        check("stop_err", {63'h0, last_err}, 64'h0);
        idle(3);
        check("stop_hold", cnt, 64'd7);

        // divide by 8
        do_write(32'h0, 32'h303);
        check("div_tcr", {32'h0, tcr}, 64'h303);
        idle(7);
        check("div_7clk", cnt, 64'd7);
        idle(1);
        check("div_8clk", cnt, 64'd8);
        idle(16);
        check("div_24clk", cnt, 64'd10);

        // out-of-range divider
        do_write(32'h0, 32'h901);
        check("div9_err", {63'h0, last_err}, 64'h1);
        check("div9_tcr", {32'h0, tcr}, 64'h303);
        idle(9);

        // 64-bit wrap
        do_write(32'h0, 32'h302);
        do_write(32'h04, 32'hFFFF_FFFF);
        do_write(32'h08, 32'hFFFF_FFFF);
        do_write(32'h0, 32'h1);
        check("wrap_pre", cnt, 64'hFFFF_FFFF_FFFF_FFFF);
        idle(1);
        check("wrap_zero", cnt, 64'h0);

        // TDR1 write on a tick cycle with TDR0=5
        do_write(32'h04, 32'd5);
        do_write(32'h08, 32'hABCD_0123);
        check("tdr1_tick", cnt, 64'hABCD_0123_0000_0005);
        idle(2);
        check("tdr1_after", cnt, 64'hABCD_0123_0000_0007);

        // unmapped addresses
        do_write(32'h14, 32'hFFFF_FFFF);
        check("unmap14_err", {63'h0, last_err}, 64'h0);
        do_write(32'h20, 32'hFFFF_FFFF);
        check("unmap20_err", {63'h0, last_err}, 64'h0);
`ifndef TIMER_HALT_EN
        do_write(32'h1C, 32'hFFFF_FFFF);
        check("unmap1c_err", {63'h0, last_err}, 64'h0);
`endif

        // carry from low to high half
        do_write(32'h04, 32'hFFFF_FFFF);
        do_write(32'h08, 32'h0);
        check("carry_pre", cnt, 64'h0000_0000_FFFF_FFFF);
        idle(1);
        check("carry_post", cnt, 64'h0000_0001_0000_0000);

        // asynchronous reset mid-count
        idle(3);
        rst_n = 1'b0;
        #1;
        check("arst_cnt",  cnt, 64'h0);
        check("arst_tcr",  {32'h0, tcr}, 64'h100);
        check("arst_tcmp", tcmp, 64'hFFFF_FFFF_FFFF_FFFF);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);

`ifdef TIMER_HALT_EN
        do_write(32'h0, 32'h1);
        idle(4);
        do_write(32'h1C, 32'h1);
        check("halt_pre", cnt, 64'd5);
        dbg_mode = 1'b1;
        idle(20);
        check("halt_frozen", cnt, 64'd5);
        check("halt_thcsr", {32'h0, thcsr}, 64'h3);
        dbg_mode = 1'b0;
        idle(3);
        check("halt_resume", cnt, 64'd8);
`endif

        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
